// File: rtl/seven_segment_capture.sv
// rtl/seven_segment_capture.sv - recovers two 4-digit decimal numbers from a multiplexed 7-segment bus
module seven_segment_capture #(
  parameter int NUM_WIDTH     = 13,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [7:0]           en_in,
  input  logic [6:0]           seg_in,
  output logic [NUM_WIDTH-1:0] NumberA_out,
  output logic [NUM_WIDTH-1:0] NumberB_out,
  output logic                 ValidA,
  output logic                 ValidB,
  output logic                 OverA,
  output logic                 OverB,
  output logic                 Error
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam longint LIMIT = (longint'(1) << NUM_WIDTH) - 1;

  logic [14:0]      s_q;
  logic [14:0]      prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0][3:0]  digit_q;
  logic [7:0]       seen_q;
  logic [7:0]       seen_next;
  logic [7:0]       en_low;
  logic             multi;
  logic             one_hot;
  logic             accept;
  logic [2:0]       slot_idx;
  logic [13:0]      value_a;
  logic [13:0]      value_b;
  logic             ok_a;
  logic             ok_b;

  function automatic logic [3:0] decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: decode = 4'd0;
      7'b1001111: decode = 4'd1;
      7'b0010010: decode = 4'd2;
      7'b0000110: decode = 4'd3;
      7'b1001100: decode = 4'd4;
      7'b0100100: decode = 4'd5;
      7'b0100000: decode = 4'd6;
      7'b0001111: decode = 4'd7;
      7'b0000000: decode = 4'd8;
      7'b0000100: decode = 4'd9;
      default:    decode = 4'hF;
    endcase
  endfunction

  function automatic logic [13:0] frame_value(input logic [3:0] d3, input logic [3:0] d2,
                                              input logic [3:0] d1, input logic [3:0] d0);
    frame_value = 14'(d3) * 14'd1000 + 14'(d2) * 14'd100 + 14'(d1) * 14'd10 + 14'(d0);
  endfunction

  // Register the raw bus and count how long the registered sample has been unchanged
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s_q    <= {8'hFF, 7'h7F};
      prev_q <= {8'hFF, 7'h7F};
      cnt_q  <= '0;
    end else begin
      s_q    <= {en_in, seg_in};
      prev_q <= s_q;
      if (s_q != prev_q)
        cnt_q <= '0;
      else if (cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Accept fires once, on the step that brings the counter to its saturation value
  always_comb begin
    en_low  = ~s_q[14:7];
    multi   = (en_low & (en_low - 8'd1)) != 8'd0;
    one_hot = (en_low != 8'd0) && !multi;
    accept  = (s_q == prev_q) && (cnt_q == CNT_MAX - CNT_W'(1));
    slot_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (en_low[i]) slot_idx = 3'(i);
  end

  // A completed half is cleared before a new accept is merged in
  always_comb begin
    seen_next = seen_q;
    if (&seen_q[3:0]) seen_next[3:0] = 4'h0;
    if (&seen_q[7:4]) seen_next[7:4] = 4'h0;
    if (accept && one_hot) seen_next[slot_idx] = 1'b1;
  end

  // Frame values and range checks for both halves
  always_comb begin
    value_a = frame_value(digit_q[3], digit_q[2], digit_q[1], digit_q[0]);
    value_b = frame_value(digit_q[7], digit_q[6], digit_q[5], digit_q[4]);
    ok_a = (digit_q[0] <= 4'd9) && (digit_q[1] <= 4'd9) && (digit_q[2] <= 4'd9) &&
           (digit_q[3] <= 4'd9) && (longint'(value_a) <= LIMIT);
    ok_b = (digit_q[4] <= 4'd9) && (digit_q[5] <= 4'd9) && (digit_q[6] <= 4'd9) &&
           (digit_q[7] <= 4'd9) && (longint'(value_b) <= LIMIT);
  end

  // Digit capture, frame completion and output strobes
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      digit_q     <= {8{4'hF}};
      seen_q      <= 8'h00;
      NumberA_out <= '0;
      NumberB_out <= '0;
      ValidA      <= 1'b0;
      ValidB      <= 1'b0;
      OverA       <= 1'b0;
      OverB       <= 1'b0;
      Error       <= 1'b0;
    end else begin
      seen_q <= seen_next;
      ValidA <= 1'b0;
      ValidB <= 1'b0;
      Error  <= accept && multi;
      if (accept && one_hot)
        digit_q[slot_idx] <= decode(s_q[6:0]);
      if (&seen_q[3:0]) begin
        if (ok_a) begin
          NumberA_out <= NUM_WIDTH'(value_a);
          ValidA      <= 1'b1;
          OverA       <= 1'b0;
        end else begin
          OverA <= 1'b1;
        end
      end
      if (&seen_q[7:4]) begin
        if (ok_b) begin
          NumberB_out <= NUM_WIDTH'(value_b);
          ValidB      <= 1'b1;
          OverB       <= 1'b0;
        end else begin
          OverB <= 1'b1;
        end
      end
    end
  end

endmodule
